// File: rtl/imem_server_pkg.sv
// Shared types and constants for the instruction-memory server.
package imem_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } imem_state_t;

    localparam logic [31:0] NOP_INSTR      = 32'hD503201F;
    localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_server_if.sv
// Fetch and program-load signals of imem_server. The optional checksum signal
// exists only when IMEM_CHECKSUM_EN is defined.
interface imem_server_if #(
    parameter int N_WORDS = 64,
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    localparam int WC_W = $clog2(N_WORDS) + 1;

    // Load handshake: a byte transfers on a rising clk edge where ld_valid && ld_ready.
    // ld_valid may be raised without waiting for ld_ready; ld_done is a one-cycle pulse.
    logic [ADDR_W-1:0]  imem_addr_F;
    logic [INSTR_W-1:0] instr_F;
    logic               instr_valid_F;
    logic               fault_F;
    logic               run;
    logic               ld_valid;
    logic [7:0]         ld_byte;
    logic               ld_ready;
    logic               ld_done;
    logic [WC_W-1:0]    wcount;
`ifdef IMEM_CHECKSUM_EN
    logic [INSTR_W-1:0] checksum;

    modport master (output imem_addr_F, ld_valid, ld_byte, ld_done,
                    input  instr_F, instr_valid_F, fault_F, run, ld_ready, wcount, checksum);
    modport slave  (input  imem_addr_F, ld_valid, ld_byte, ld_done,
                    output instr_F, instr_valid_F, fault_F, run, ld_ready, wcount, checksum);
`else
    modport master (output imem_addr_F, ld_valid, ld_byte, ld_done,
                    input  instr_F, instr_valid_F, fault_F, run, ld_ready, wcount);
    modport slave  (input  imem_addr_F, ld_valid, ld_byte, ld_done,
                    output instr_F, instr_valid_F, fault_F, run, ld_ready, wcount);
`endif
endinterface

// File: rtl/imem_server_byte_packer.sv
// Assembles little-endian bytes into words; flush emits a zero-padded partial word.
module byte_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    input  logic        i_flush,
    output logic        o_word_valid,
    output logic [31:0] o_word
);
    logic [1:0]  r_bcnt;
    logic [31:0] r_word;
    logic [31:0] w_word;
    logic        w_last;

    // The byte arriving this cycle is merged before any flush, so it is never lost.
    always_comb begin
        w_word = r_word;
        if (i_byte_valid) w_word[{r_bcnt, 3'b000} +: 8] = i_byte;
    end

    assign w_last       = i_byte_valid && (r_bcnt == 2'(BYTES_PER_WORD - 1));
    assign o_word_valid = w_last || (i_flush && (i_byte_valid || (r_bcnt != 2'd0)));
    assign o_word       = w_word;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bcnt <= 2'd0;
            r_word <= '0;
        end else if (o_word_valid || i_flush) begin
            r_bcnt <= 2'd0;
            r_word <= '0;
        end else if (i_byte_valid) begin
            r_bcnt <= r_bcnt + 2'd1;
            r_word <= w_word;
        end
    end
endmodule

// File: rtl/imem_server.sv
// Instruction memory: byte-serial program load, then 1-cycle registered fetch with a
// sticky fault. Defining IMEM_CHECKSUM_EN adds an XOR checksum of loaded words.
module imem_server
    import imem_pkg::*;
#(
    parameter int N_WORDS = 64,
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    imem_server_if.slave  bus,
    output imem_state_t   o_dbg_state
);
    localparam int IDX_W = $clog2(N_WORDS);
    localparam int WC_W  = IDX_W + 1;

    logic [INSTR_W-1:0] r_mem [N_WORDS];
    imem_state_t        r_state;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               r_fault;
    logic               r_run;
    logic               r_ld_ready;
    logic [WC_W-1:0]    r_wcount;

    logic               w_byte_valid;
    logic               w_flush;
    logic               w_wr;
    logic [31:0]        w_word;
    logic [IDX_W-1:0]   w_idx;
    logic               w_fault;

    // r_ld_ready is only high in LOAD while memory still has room.
    assign w_byte_valid = bus.ld_valid && r_ld_ready;
    assign w_flush      = bus.ld_done && r_ld_ready;

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_byte_valid (w_byte_valid),
        .i_byte       (bus.ld_byte),
        .i_flush      (w_flush),
        .o_word_valid (w_wr),
        .o_word       (w_word)
    );

    assign w_idx   = bus.imem_addr_F[IDX_W+1:2];
    assign w_fault = (bus.imem_addr_F[1:0] != 2'b00)
                  || (|bus.imem_addr_F[ADDR_W-1:IDX_W+2])
                  || ({1'b0, w_idx} >= r_wcount);

    // Array is deliberately not reset; a write is suppressed in the reset cycle.
    always_ff @(posedge clk) begin
        if (reset && w_wr) r_mem[r_wcount[IDX_W-1:0]] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= LOAD;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
            r_run      <= 1'b0;
            r_wcount   <= '0;
            r_ld_ready <= 1'b1;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_wr) begin
                        r_wcount <= r_wcount + 1'b1;
                        if (r_wcount == WC_W'(N_WORDS - 1)) r_ld_ready <= 1'b0;
                    end
                    if (r_wcount == WC_W'(N_WORDS) || w_flush) begin
                        r_state    <= RUN;
                        r_run      <= 1'b1;
                        r_ld_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_fault) begin
                        r_state <= HALT;
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                        r_fault <= 1'b1;
                        r_run   <= 1'b0;
                    end else begin
                        r_instr <= r_mem[w_idx];
                        r_valid <= 1'b1;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: r_state <= HALT;
            endcase
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [INSTR_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (!reset)    r_checksum <= '0;
        else if (w_wr) r_checksum <= r_checksum ^ w_word;
    end

    assign bus.checksum = r_checksum;
`endif

    assign bus.instr_F       = r_instr;
    assign bus.instr_valid_F = r_valid;
    assign bus.fault_F       = r_fault;
    assign bus.run           = r_run;
    assign bus.ld_ready      = r_ld_ready;
    assign bus.wcount        = r_wcount;
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_imem_server.sv
// Randomized scoreboard bench for imem_server against a queue-based program model.
module tb_imem_server;
    import imem_pkg::*;

    localparam int N_WORDS = 64;
    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int EW      = 16 + 1 + 1 + 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    imem_state_t dbg_state;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    imem_server_if #(.N_WORDS(N_WORDS), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    imem_server #(.N_WORDS(N_WORDS), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [31:0]   m_words[$];
    logic [31:0]   m_cur;
    int            m_cnt;
    logic [31:0]   m_xor;
    bit            m_halt;
    logic [7:0]    ld_q[$];
    logic [EW-1:0] exp_q[$];

    task automatic model_reset();
        m_words.delete();
        m_cur = 0; m_cnt = 0; m_xor = 0; m_halt = 0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        m_cur = m_cur + (32'(b) << (8 * m_cnt));
        m_cnt++;
        if (m_cnt == 4) begin
            m_words.push_back(m_cur); m_xor ^= m_cur; m_cur = 0; m_cnt = 0;
        end
    endtask

    task automatic model_flush();
        if (m_cnt != 0) begin
            m_words.push_back(m_cur); m_xor ^= m_cur; m_cur = 0; m_cnt = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0][49:34] == cyc[15:0]) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            chk("instr_valid_F", 64'(bus.instr_valid_F), 64'(e[33]));
            chk("fault_F",       64'(bus.fault_F),       64'(e[32]));
            chk("instr_F",       64'(bus.instr_F),       64'(e[31:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.ld_valid = 0; bus.ld_done = 0; bus.ld_byte = 0; bus.imem_addr_F = 0;
        @(negedge clk);
        model_reset();
        chk("rst instr_F", 64'(bus.instr_F), 0);
        chk("rst instr_valid_F", 64'(bus.instr_valid_F), 0);
        chk("rst fault_F", 64'(bus.fault_F), 0);
        chk("rst run", 64'(bus.run), 0);
        chk("rst wcount", 64'(bus.wcount), 0);
        chk("rst ld_ready", 64'(bus.ld_ready), 1);
`ifdef IMEM_CHECKSUM_EN
        chk("rst checksum", 64'(bus.checksum), 0);
`endif
        reset = 1'b1;
    endtask

    // Called at a negedge; returns at a negedge. Sends ld_q, optionally ending with ld_done.
    task automatic drive_load(input bit with_done, input bit done_on_last, input int gap_max);
        bit rdy;
        for (int i = 0; i < ld_q.size(); i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                bus.ld_valid = 0; bus.ld_done = 0;
                @(negedge clk);
            end
            bus.ld_valid = 1;
            bus.ld_byte  = ld_q[i];
            bus.ld_done  = with_done && done_on_last && (i == ld_q.size() - 1);
            rdy = bus.ld_ready;
            @(negedge clk);
            chk("ld_ready during load", 64'(rdy), 1);
            if (rdy) model_accept(ld_q[i]);
        end
        bus.ld_valid = 0;
        bus.ld_done  = 0;
        if (with_done && (!done_on_last || ld_q.size() == 0)) begin
            bus.ld_done = 1;
            @(negedge clk);
            bus.ld_done = 0;
        end
        if (with_done) model_flush();
    endtask

    task automatic wait_run_and_check();
        int k = 0;
        while (!bus.run && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("run after load", 64'(bus.run), 1);
        chk("wcount after load", 64'(bus.wcount), 64'(m_words.size()));
        chk("ld_ready after load", 64'(bus.ld_ready), 0);
`ifdef IMEM_CHECKSUM_EN
        chk("checksum", 64'(bus.checksum), 64'(m_xor));
`endif
    endtask

    // Drive one fetch address at a negedge; the response is due after the next posedge.
    task automatic fetch(input logic [63:0] a);
        logic [EW-1:0] e;
        bus.imem_addr_F = a;
        if (!m_halt && (a % 4 == 0) && (a / 4 < 64'(m_words.size())))
            e = {cyc[15:0] + 16'd1, 1'b1, 1'b0, m_words[a / 4]};
        else begin
            m_halt = 1;
            e = {cyc[15:0] + 16'd1, 1'b0, 1'b1, NOP_INSTR};
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 5) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard drained", 64'(exp_q.size()), 0);
    endtask

    task automatic random_bytes(input int n);
        ld_q.delete();
        for (int i = 0; i < n; i++) ld_q.push_back(8'($urandom));
    endtask

    function automatic logic [63:0] rand_valid_addr();
        return 64'(4 * $urandom_range(m_words.size() - 1, 0));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        bus.imem_addr_F = 0; bus.ld_valid = 0; bus.ld_byte = 0; bus.ld_done = 0;

        // 1: single word, done after last byte
        do_reset();
        ld_q = '{8'h13, 8'h00, 8'h80, 8'hD2};
        drive_load(1, 0, 0);
        wait_run_and_check();
        chk("first word model", 64'(m_words[0]), 64'h00000000D2800013);
        fetch(0);
        drain();

        // 2: eight words, back-to-back fetches
        do_reset();
        random_bytes(32);
        drive_load(1, 1, 2);
        wait_run_and_check();
        for (int i = 0; i < 8; i++) fetch(64'(4 * i));
        drain();

        // 3: partial word with done on the last byte
        do_reset();
        ld_q = '{8'hAA, 8'hBB, 8'hCC};
        drive_load(1, 1, 0);
        wait_run_and_check();
        fetch(0);
        drain();

        // 4: misaligned address halts; later good address stays halted
        do_reset();
        random_bytes(8);
        drive_load(1, 0, 1);
        wait_run_and_check();
        fetch(64'h6); fetch(64'h0); fetch(64'h4);
        drain();
        chk("dbg_state halt", 64'(dbg_state), 64'(HALT));
        chk("run in halt", 64'(bus.run), 0);

        // 5: unloaded address, then one reset cycle
        do_reset();
        random_bytes(8);
        drive_load(1, 1, 0);
        wait_run_and_check();
        fetch(64'h8); fetch(64'h0);
        drain();
        do_reset();

        // 6: stream the full memory without ld_done
        random_bytes(N_WORDS * 4);
        drive_load(0, 0, 0);
        wait_run_and_check();
        for (int i = 0; i < 30; i++) fetch(rand_valid_addr());
        fetch(rand_valid_addr() | (64'h1 << $urandom_range(63, 8)));
        drain();

        // 7: ld_done with nothing loaded
        do_reset();
        ld_q.delete();
        drive_load(1, 0, 0);
        wait_run_and_check();
        fetch(0);
        drain();

        // 8: reset in the middle of a load, then a fresh partial load
        do_reset();
        random_bytes(6);
        drive_load(0, 0, 0);
        do_reset();
        ld_q = '{8'hAA, 8'hBB, 8'hCC};
        drive_load(1, 0, 0);
        wait_run_and_check();
        fetch(0);
        drain();

        // 9: randomized rounds
        for (int r = 0; r < 8; r++) begin
            do_reset();
            random_bytes($urandom_range(48, 1));
            drive_load(1, 1'($urandom_range(1, 0)), 2);
            wait_run_and_check();
            for (int i = 0; i < 12; i++) begin
                case ($urandom_range(9, 0))
                    0: fetch(rand_valid_addr() | 64'($urandom_range(3, 1)));
                    1: fetch(64'(4 * $urandom_range(N_WORDS - 1, m_words.size())));
                    2: fetch(64'h1 << $urandom_range(63, 8));
                    default: fetch(rand_valid_addr());
                endcase
            end
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
